// File: rtl/hcpf_seq_pkg.sv
// Shared types and constants for the HCPFTL request sequencer.
// The optional stall counter is enabled with SEQ_STALL_CNT_EN.
package hcpf_seq_pkg;

   localparam int unsigned REQ_W_DEF = 64;

   localparam logic [1:0] REQ_READ  = 2'b00;
   localparam logic [1:0] REQ_WRITE = 2'b01;
   localparam logic [1:0] REQ_BUFWR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2,
      ST_FIN   = 2'd3
   } seq_state_e;

   // A pass must contain between one and DEPTH entries.
   function automatic logic cfg_count_ok(input int unsigned cnt, input int unsigned depth);
      return (cnt != 32'd0) && (cnt <= depth);
   endfunction

endpackage

// File: rtl/hcpf_seq_table.sv
// Request table: DEPTH x REQ_W register array, one write port and one
// combinational read port. Contents are deliberately not reset.
module hcpf_seq_table import hcpf_seq_pkg::*; #(
   parameter int REQ_W = int'(REQ_W_DEF),
   parameter int DEPTH = 32,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_addr_i,
   input  logic [REQ_W-1:0] wr_data_i,
   input  logic [IDX_W-1:0] rd_addr_i,
   output logic [REQ_W-1:0] rd_data_o
);

   logic [REQ_W-1:0] mem_q [DEPTH];

   // Table write port.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/hcpf_req_sequencer.sv
// Replays a run-time loaded request table into the HCPFTL RWrequest port.
// Defining SEQ_STALL_CNT_EN adds the stall_cnt port and counter.
module hcpf_req_sequencer import hcpf_seq_pkg::*; #(
   parameter int REQ_W  = int'(REQ_W_DEF),
   parameter int DEPTH  = 32,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int GAP_W  = 4,
   parameter int LOOP_W = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              tbl_wr_en,
   input  logic [IDX_W-1:0]  tbl_wr_addr,
   input  logic [REQ_W-1:0]  tbl_wr_data,
   input  logic [IDX_W:0]    cfg_count,
   input  logic [LOOP_W-1:0] cfg_loops,
   input  logic [GAP_W-1:0]  cfg_gap,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [REQ_W-1:0]  req_bits,
   output logic              ptr_reset
`ifdef SEQ_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   seq_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LOOP_W-1:0] loop_q, loop_d, loops_q, loops_d;
   logic [IDX_W:0]    count_q, count_d;
   logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
   logic              abort_pend_q, abort_pend_d;
   logic              valid_q, done_q, done_d, err_q, err_d;
   logic [REQ_W-1:0]  bits_q, rd_data_s;
   logic              load_s, accept_s, last_s, end_s, cfg_ok_s, busy_s;

   assign busy_s   = (state_q != ST_IDLE);
   assign cfg_ok_s = cfg_count_ok(32'(cfg_count), 32'(DEPTH));
   assign accept_s = valid_q && req_ready;
   assign last_s   = ({1'b0, idx_q} == (count_q - (IDX_W+1)'(1)));
   // Compared one bit wider so loops==max never wraps into an early match.
   assign end_s    = (loops_q != '0) &&
                     (({1'b0, loop_q} + (LOOP_W+1)'(1)) == {1'b0, loops_q});

   hcpf_seq_table #(.REQ_W(REQ_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
      .clock     (clock),
      .wr_en_i   (tbl_wr_en && !busy_s),
      .wr_addr_i (tbl_wr_addr),
      .wr_data_i (tbl_wr_data),
      .rd_addr_i (idx_d),
      .rd_data_o (rd_data_s)
   );

   // Next-state, counter and pulse logic.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      loop_d       = loop_q;
      loops_d      = loops_q;
      count_d      = count_q;
      gap_d        = gap_q;
      gap_cnt_d    = gap_cnt_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      err_d        = tbl_wr_en && busy_s;
      load_s       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && cfg_ok_s) begin
               state_d      = ST_ISSUE;
               count_d      = cfg_count;
               loops_d      = cfg_loops;
               gap_d        = cfg_gap;
               idx_d        = '0;
               loop_d       = '0;
               abort_pend_d = 1'b0;
               load_s       = 1'b1;
            end else if (start) begin
               err_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (accept_s) begin
               if (last_s) begin
                  idx_d  = '0;
                  loop_d = loop_q + LOOP_W'(1);
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
               // Abort only takes effect once the in-flight word is accepted.
               if ((last_s && end_s) || abort || abort_pend_q) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
               end else if (gap_q == '0) begin
                  load_s = 1'b1;
               end else begin
                  state_d   = ST_GAP;
                  gap_cnt_d = gap_q;
               end
            end else if (abort) begin
               abort_pend_d = 1'b1;
            end else begin
               abort_pend_d = abort_pend_q;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_FIN;
               done_d  = 1'b1;
            end else if (gap_cnt_q == GAP_W'(1)) begin
               state_d = ST_ISSUE;
               load_s  = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         ST_FIN: begin
            state_d      = ST_IDLE;
            abort_pend_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         loop_q       <= '0;
         loops_q      <= '0;
         count_q      <= '0;
         gap_q        <= '0;
         gap_cnt_q    <= '0;
         abort_pend_q <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         bits_q       <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         loop_q       <= loop_d;
         loops_q      <= loops_d;
         count_q      <= count_d;
         gap_q        <= gap_d;
         gap_cnt_q    <= gap_cnt_d;
         abort_pend_q <= abort_pend_d;
         valid_q      <= (state_d == ST_ISSUE);
         done_q       <= done_d;
         err_q        <= err_d;
         bits_q       <= load_s ? rd_data_s : bits_q;
      end
   end

`ifdef SEQ_STALL_CNT_EN
   logic [31:0] stall_q;

   // Saturating count of back-pressured cycles, cleared by an accepted start.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_q <= 32'd0;
      end else if (!busy_s && start && cfg_ok_s) begin
         stall_q <= 32'd0;
      end else if (valid_q && !req_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end else begin
         stall_q <= stall_q;
      end
   end

   assign stall_cnt = stall_q;
`endif

   assign busy      = busy_s;
   assign done      = done_q;
   assign err       = err_q;
   assign req_valid = valid_q;
   assign req_bits  = bits_q;
   assign ptr_reset = (state_q == ST_ISSUE) && req_ready && last_s;

endmodule

// File: tb/tb_hcpf_req_sequencer.sv
// Directed self-checking bench for hcpf_req_sequencer (default parameters).
module tb_hcpf_req_sequencer;

   localparam int REQ_W  = 64;
   localparam int DEPTH  = 32;
   localparam int IDX_W  = 5;
   localparam int GAP_W  = 4;
   localparam int LOOP_W = 8;

   logic              clock = 1'b0;
   logic              resetn;
   logic              tbl_wr_en;
   logic [IDX_W-1:0]  tbl_wr_addr;
   logic [REQ_W-1:0]  tbl_wr_data;
   logic [IDX_W:0]    cfg_count;
   logic [LOOP_W-1:0] cfg_loops;
   logic [GAP_W-1:0]  cfg_gap;
   logic              start, abort, req_ready;
   logic              busy, done, err, req_valid, ptr_reset;
   logic [REQ_W-1:0]  req_bits;
`ifdef SEQ_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   hcpf_req_sequencer #(.REQ_W(REQ_W), .DEPTH(DEPTH), .GAP_W(GAP_W), .LOOP_W(LOOP_W)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .tbl_wr_en   (tbl_wr_en),
      .tbl_wr_addr (tbl_wr_addr),
      .tbl_wr_data (tbl_wr_data),
      .cfg_count   (cfg_count),
      .cfg_loops   (cfg_loops),
      .cfg_gap     (cfg_gap),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_bits    (req_bits),
      .ptr_reset   (ptr_reset)
`ifdef SEQ_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int addr, input logic [63:0] data);
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = IDX_W'(addr);
      tbl_wr_data = data;
      tick();
      tbl_wr_en   = 1'b0;
   endtask

   task automatic start_seq(input int cnt, input int loops, input int gap);
      cfg_count = (IDX_W+1)'(cnt);
      cfg_loops = LOOP_W'(loops);
      cfg_gap   = GAP_W'(gap);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_w;
      resetn = 1'b0; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
      cfg_count = '0; cfg_loops = '0; cfg_gap = '0;
      start = 1'b0; abort = 1'b0; req_ready = 1'b1;
      #12;
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", req_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_bits", req_bits, 64'h0);
      chk("rst_ptr", ptr_reset, 1'b0);
`ifdef SEQ_STALL_CNT_EN
      chk("rst_stall", stall_cnt, 32'd0);
`endif
      resetn = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) wr(i, 64'hA0 + 64'(i));

      // Single pass, back-to-back; a second start while busy is ignored.
      start_seq(4, 1, 0);
      chk("t1_valid0", req_valid, 1'b1);
      chk("t1_bits0", req_bits, 64'hA0);
      chk("t1_ptr0", ptr_reset, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_bits1", req_bits, 64'hA1);
      chk("t1_noerr", err, 1'b0);
      tick();
      chk("t1_bits2", req_bits, 64'hA2);
      tick();
      chk("t1_bits3", req_bits, 64'hA3);
      chk("t1_ptr3", ptr_reset, 1'b1);
      tick();
      chk("t1_done", done, 1'b1);
      chk("t1_valid_fin", req_valid, 1'b0);
      chk("t1_busy_fin", busy, 1'b1);
      tick();
      chk("t1_done_clr", done, 1'b0);
      chk("t1_idle", busy, 1'b0);

      // Three entries, two passes, gap of two idle cycles.
      start_seq(3, 2, 2);
      for (int k = 0; k < 6; k++) begin
         exp_w = 64'hA0 + 64'(k % 3);
         chk("t2_valid", req_valid, 1'b1);
         chk("t2_bits", req_bits, exp_w);
         chk("t2_ptr", ptr_reset, ((k % 3) == 2) ? 1'b1 : 1'b0);
         if (k < 5) begin
            tick();
            chk("t2_gap_a", req_valid, 1'b0);
            tick();
            chk("t2_gap_b", req_valid, 1'b0);
            tick();
         end
      end
      tick();
      chk("t2_done", done, 1'b1);
      tick();
      chk("t2_idle", busy, 1'b0);

      // Back-pressure for five cycles on entry 1.
      start_seq(4, 1, 0);
      chk("t3_bits0", req_bits, 64'hA0);
      tick();
      req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", req_valid, 1'b1);
         chk("t3_hold_bits", req_bits, 64'hA1);
         tick();
      end
      req_ready = 1'b1;
      chk("t3_bits1", req_bits, 64'hA1);
      tick();
      chk("t3_bits2", req_bits, 64'hA2);
      tick();
      chk("t3_bits3", req_bits, 64'hA3);
      tick();
      chk("t3_done", done, 1'b1);
`ifdef SEQ_STALL_CNT_EN
      chk("t3_stall", stall_cnt, 32'd5);
`endif
      tick();

      // Endless run aborted while entry 2 is back-pressured.
      start_seq(4, 0, 0);
      tick();
      tick();
      chk("t4_bits2", req_bits, 64'hA2);
      req_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("t4_hold_valid", req_valid, 1'b1);
         chk("t4_hold_bits", req_bits, 64'hA2);
         tick();
      end
      chk("t4_valid_last", req_valid, 1'b1);
      req_ready = 1'b1;
      chk("t4_ptr", ptr_reset, 1'b0);
      tick();
      chk("t4_done", done, 1'b1);
      chk("t4_valid_fin", req_valid, 1'b0);
      tick();
      chk("t4_idle", busy, 1'b0);
      tick();
      chk("t4_no_valid", req_valid, 1'b0);

      // Illegal starts and a table write while busy.
      start_seq(0, 1, 0);
      chk("t5_err_cnt0", err, 1'b1);
      chk("t5_busy_cnt0", busy, 1'b0);
      tick();
      chk("t5_err_clr", err, 1'b0);
      start_seq(33, 1, 0);
      chk("t5_err_cnt33", err, 1'b1);
      chk("t5_busy_cnt33", busy, 1'b0);
      req_ready = 1'b0;
      start_seq(4, 1, 0);
      chk("t5_bits0", req_bits, 64'hA0);
      tbl_wr_en = 1'b1; tbl_wr_addr = 5'd1; tbl_wr_data = 64'hDEAD;
      tick();
      tbl_wr_en = 1'b0;
      chk("t5_err_wr", err, 1'b1);
      chk("t5_bits0_hold", req_bits, 64'hA0);
      req_ready = 1'b1;
      tick();
      chk("t5_bits1_kept", req_bits, 64'hA1);
      chk("t5_err_wr_clr", err, 1'b0);
      tick();
      tick();
      tick();
      chk("t5_done", done, 1'b1);
      tick();

      // Asynchronous reset in the middle of ISSUE, then a clean replay.
      req_ready = 1'b0;
      start_seq(4, 1, 0);
      chk("t6_valid", req_valid, 1'b1);
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_rst_valid", req_valid, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_bits", req_bits, 64'h0);
      #2;
      resetn = 1'b1;
      req_ready = 1'b1;
      tick();
      start_seq(4, 1, 0);
      chk("t6_replay0", req_bits, 64'hA0);
      tick();
      chk("t6_replay1", req_bits, 64'hA1);
      tick();
      tick();
      tick();
      chk("t6_done", done, 1'b1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
